kill_detect: RTL and testbench
==============================

KILL_DETECT -- requirements
Module: kill_detect

Interface
REQ-001 Parameter N_ENEMIES, default 8, number of enemy slots.
REQ-002 Parameter H_LAST, default 639, x of last active pixel in a frame.
REQ-003 Parameter V_LAST, default 479, y of last active pixel in a frame.
REQ-004 clk  in  1  50MHz clock.
REQ-005 reset  in  1  asynchronous active-low reset; state cleared while 0.
REQ-006 x  in  10  x-coordinate of current pixel.
REQ-007 y  in  9  y-coordinate of current pixel.
REQ-008 bullet_px  in  1  1 if the bullet renders at (x, y).
REQ-009 enemy_px  in  N_ENEMIES  bit i is 1 if enemy slot i renders at (x, y).
REQ-010 killed  out  1  one-cycle pulse per enemy killed; drives the scoreboard.
REQ-011 kill_slot  out  N_ENEMIES  one-hot slot killed this cycle; all-zero when killed=0.
REQ-012 bullet_hit  out  1  one-cycle pulse telling the bullet to retire.
REQ-013 busy  out  1  1 while in DRAIN.

Function
REQ-014 The FSM SHALL have 2 states: SCAN (accumulate hits) and DRAIN (report hits).
REQ-015 In SCAN, at each clk edge, the block SHALL set hit[i] for every i with bullet_px & enemy_px[i].
- Multiple slots overlapping on one pixel set multiple flags in the same cycle.
- hit[i] is sticky until drained.
REQ-016 In SCAN, the edge sampling x==H_LAST & y==V_LAST SHALL include that pixel's overlap.
- On that edge: SCAN->DRAIN, idx=0.
REQ-017 In DRAIN, the block SHALL visit one slot per cycle, idx 0..N_ENEMIES-1; DRAIN lasts exactly N_ENEMIES cycles.
- Then DRAIN->SCAN.
REQ-018 When the visited slot has hit[idx]=1, the block SHALL, registered one cycle later:
- pulse killed=1;
- drive kill_slot=1<<idx;
- clear hit[idx].
REQ-019 Exactly one killed pulse SHALL occur per set hit flag; never two in one cycle.
REQ-020 bullet_hit SHALL pulse for one cycle on the DRAIN->SCAN transition edge iff any flag was set on entry to DRAIN.
REQ-021 In DRAIN, bullet_px/enemy_px SHALL be ignored and frame-end coordinates SHALL NOT restart DRAIN.
REQ-022 A frame with no overlaps SHALL still traverse DRAIN and produce no killed or bullet_hit pulses.
REQ-023 idx width SHALL be $clog2(N_ENEMIES); idx SHALL not wrap within a DRAIN.

Reset
REQ-024 While reset=0, the block SHALL hold:
- state=SCAN, idx=0, all hit flags 0;
- killed=0, kill_slot=0, bullet_hit=0, busy=0.
REQ-025 Reset asserted mid-DRAIN SHALL discard pending hits with no further pulses.
REQ-026 After release, the first clk edge SHALL resume SCAN accumulation.

Configuration
REQ-027 With macro KILL_LIMIT_EN defined, at most one kill SHALL be reported per frame: the lowest-index hit slot.
- Remaining flags are cleared silently at DRAIN exit.
- DRAIN length is unchanged.
REQ-028 Without KILL_LIMIT_EN, every hit slot SHALL be reported per REQ-018.

Verification
REQ-029 Bullet overlaps slot 2 at (100,50); run to frame end -> DRAIN:
- killed=1 and kill_slot=8'b00000100 for exactly one cycle;
- bullet_hit pulses once;
- busy=1 for 8 cycles.
REQ-030 One pixel with bullet_px=1, enemy_px=8'b10010001 -> killed pulses 3 times, kill_slot 0x01, 0x10, 0x80 in slot order.
- With KILL_LIMIT_EN defined: one pulse, kill_slot 0x01.
REQ-031 Slot 5 overlaps on 40 pixels in one frame -> exactly one killed pulse, kill_slot=0x20.
REQ-032 Overlap present only on the cycles DRAIN is active -> no hit recorded; the next frame reports nothing.
REQ-033 Reset driven 0 after slot 1 reported and before slot 6 -> outputs 0 immediately; no slot 6 pulse.
REQ-034 Frame with no overlaps -> killed, bullet_hit stay 0; busy high 8 cycles.
- Connected to the scoreboard, 3 frames with one kill each -> score count 3.

Source files
------------

// File: rtl/kill_detect.sv
// kill_detect: collects bullet/enemy pixel overlaps over one frame, then
// walks every enemy slot for one cycle each and reports each kill as a pulse.
// Optional build macro KILL_LIMIT_EN: report only the lowest-index kill
// per frame. Any other hit flags are dropped silently when DRAIN ends.
//
//   state | meaning
//   SCAN  | accumulate sticky hit flags from pixel overlaps
//   DRAIN | visit slot idx = 0..N_ENEMIES-1, one per cycle, report hits
module kill_detect #(
  parameter int N_ENEMIES = 8,
  parameter int H_LAST    = 639,
  parameter int V_LAST    = 479
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           x,
  input  logic [8:0]           y,
  input  logic                 bullet_px,
  input  logic [N_ENEMIES-1:0] enemy_px,
  output logic                 killed,
  output logic [N_ENEMIES-1:0] kill_slot,
  output logic                 bullet_hit,
  output logic                 busy
);

  localparam int IDX_W = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ENEMIES - 1);

  typedef enum logic {SCAN = 1'b0, DRAIN = 1'b1} state_t;

  state_t               state, state_d;
  logic [IDX_W-1:0]     idx, idx_d;
  logic [N_ENEMIES-1:0] hit, hit_d;
  logic                 any_hit, any_hit_d;
  logic                 killed_d, bullet_hit_d;
  logic [N_ENEMIES-1:0] kill_slot_d;
  logic                 frame_end;

`ifdef KILL_LIMIT_EN
  // Set once this frame's single permitted kill has been reported.
  logic                 reported, reported_d;
`endif

  assign frame_end = (x == 10'(H_LAST)) && (y == 9'(V_LAST));
  assign busy      = (state == DRAIN);

  // State, slot pointer, hit flags and registered pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SCAN;
      idx        <= '0;
      hit        <= '0;
      any_hit    <= 1'b0;
      killed     <= 1'b0;
      kill_slot  <= '0;
      bullet_hit <= 1'b0;
`ifdef KILL_LIMIT_EN
      reported   <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      hit        <= hit_d;
      any_hit    <= any_hit_d;
      killed     <= killed_d;
      kill_slot  <= kill_slot_d;
      bullet_hit <= bullet_hit_d;
`ifdef KILL_LIMIT_EN
      reported   <= reported_d;
`endif
    end
  end

  // Next-state logic: accumulate in SCAN, walk the slots in DRAIN.
  always_comb begin
    state_d      = state;
    idx_d        = idx;
    hit_d        = hit;
    any_hit_d    = any_hit;
    killed_d     = 1'b0;
    kill_slot_d  = '0;
    bullet_hit_d = 1'b0;
`ifdef KILL_LIMIT_EN
    reported_d   = reported;
`endif
    case (state)
      SCAN: begin
        // The frame-end pixel's own overlap is folded in before leaving SCAN.
        hit_d = hit | (enemy_px & {N_ENEMIES{bullet_px}});
        if (frame_end) begin
          state_d   = DRAIN;
          idx_d     = '0;
          any_hit_d = |hit_d;
`ifdef KILL_LIMIT_EN
          reported_d = 1'b0;
`endif
        end
      end
      DRAIN: begin
        if (hit[idx]) begin
`ifdef KILL_LIMIT_EN
          if (!reported) begin
            killed_d    = 1'b1;
            kill_slot_d = N_ENEMIES'(1) << idx;
            reported_d  = 1'b1;
          end
`else
          killed_d    = 1'b1;
          kill_slot_d = N_ENEMIES'(1) << idx;
`endif
          hit_d[idx] = 1'b0;
        end
        if (idx == IDX_LAST) begin
          // Leaving DRAIN: retire the bullet if anything was hit this frame.
          state_d      = SCAN;
          idx_d        = '0;
          hit_d        = '0;
          bullet_hit_d = any_hit;
          any_hit_d    = 1'b0;
        end else begin
          idx_d = idx + IDX_W'(1);
        end
      end
      default: begin
        state_d = SCAN;
        idx_d   = '0;
        hit_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_kill_detect.sv
// tb_kill_detect: randomized frames checked against a set-based model of
// which enemy slots a frame's overlaps should report, and in what order.
module tb_kill_detect;
  localparam int N      = 8;
  localparam int H_LAST = 639;
  localparam int V_LAST = 479;

  typedef struct {
    logic [9:0] px;
    logic [8:0] py;
    logic       b;
    logic [7:0] e;
  } pix_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] x = '0;
  logic [8:0] y = '0;
  logic       bullet_px = 1'b0;
  logic [7:0] enemy_px = '0;
  logic       killed;
  logic [7:0] kill_slot;
  logic       bullet_hit;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int score  = 0;

  kill_detect #(.N_ENEMIES(N), .H_LAST(H_LAST), .V_LAST(V_LAST)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .bullet_px(bullet_px),
    .enemy_px(enemy_px), .killed(killed), .kill_slot(kill_slot),
    .bullet_hit(bullet_hit), .busy(busy)
  );

  always #10 clk = ~clk;

  // Scoreboard: one point per killed pulse.
  always @(negedge clk) if (killed === 1'b1) score++;

  function automatic pix_t rand_pix(input bit overlap);
    pix_t p;
    p.px = 10'($urandom_range(0, H_LAST));
    p.py = 9'($urandom_range(0, V_LAST));
    if (p.px == 10'(H_LAST) && p.py == 9'(V_LAST)) p.py = '0;
    p.b = overlap ? 1'($urandom) : 1'b0;
    p.e = overlap ? 8'($urandom) : 8'h00;
    return p;
  endfunction

  function automatic pix_t mk_pix(input int px, input int py, input bit b, input logic [7:0] e);
    pix_t p;
    p.px = 10'(px); p.py = 9'(py); p.b = b; p.e = e;
    return p;
  endfunction

  task automatic apply(input pix_t p);
    x = p.px; y = p.py; bullet_px = p.b; enemy_px = p.e;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Plays scan pixels (last one must be the frame-end pixel), then the DRAIN
  // window with garbage inputs, checking every sampled output.
  task automatic play_frame(input pix_t pix[$], input string name);
    logic [7:0] hits;
    logic [7:0] report;
    logic [7:0] exp_slot;
    bit         found;
    hits = 8'h00;
    foreach (pix[i]) begin
      if (pix[i].b) hits = hits | pix[i].e;
      apply(pix[i]);
      checks++;
      if (killed !== 1'b0 || bullet_hit !== 1'b0 || busy !== (i == pix.size() - 1)) begin
        errors++;
        $display("FAIL %s scan px%0d: killed=%b bullet_hit=%b busy=%b expected 0 0 %0d",
                 name, i, killed, bullet_hit, busy, (i == pix.size() - 1));
      end
    end
    report = hits;
`ifdef KILL_LIMIT_EN
    report = 8'h00;
    found  = 1'b0;
    for (int k = 0; k < N; k++)
      if (hits[k] && !found) begin report[k] = 1'b1; found = 1'b1; end
`else
    found = 1'b0;
`endif
    for (int k = 0; k < N; k++) begin
      pix_t junk;
      junk.px = ($urandom_range(0, 1) == 0) ? 10'(H_LAST) : 10'($urandom_range(0, H_LAST));
      junk.py = (junk.px == 10'(H_LAST)) ? 9'(V_LAST) : 9'($urandom_range(0, V_LAST));
      junk.b  = 1'b1;
      junk.e  = 8'($urandom);
      apply(junk);
      exp_slot = report[k] ? (8'h01 << k) : 8'h00;
      checks++;
      if (killed !== report[k] || kill_slot !== exp_slot) begin
        errors++;
        $display("FAIL %s drain slot%0d: killed=%b kill_slot=%h expected %b %h",
                 name, k, killed, kill_slot, report[k], exp_slot);
      end
      checks++;
      if (bullet_hit !== (k == N - 1 && hits != 8'h00) || busy !== (k < N - 1)) begin
        errors++;
        $display("FAIL %s drain step%0d: bullet_hit=%b busy=%b expected %0d %0d",
                 name, k, bullet_hit, busy, (k == N - 1 && hits != 8'h00), (k < N - 1));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pix_t p;
      p = rand_pix(1'b1);
      if (i == 3) begin p.px = 10'(H_LAST); p.py = 9'(V_LAST); end
      apply(p);
      checks++;
      if (killed !== 1'b0 || kill_slot !== 8'h00 || bullet_hit !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: killed=%b kill_slot=%h bullet_hit=%b busy=%b expected all 0",
                 i, killed, kill_slot, bullet_hit, busy);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_single_slot();
    pix_t q[$];
    for (int i = 0; i < 5; i++) q.push_back(rand_pix(1'b0));
    q.push_back(mk_pix(100, 50, 1'b1, 8'b0000_0100));
    for (int i = 0; i < 5; i++) q.push_back(rand_pix(1'b0));
    q.push_back(mk_pix(H_LAST, V_LAST, 1'b0, 8'h00));
    play_frame(q, "single_slot2");
  endtask

  task automatic test_multi_overlap();
    pix_t q[$];
    q.push_back(rand_pix(1'b0));
    q.push_back(mk_pix(200, 100, 1'b1, 8'b1001_0001));
    q.push_back(mk_pix(H_LAST, V_LAST, 1'b0, 8'hFF));
    play_frame(q, "multi_overlap");
  endtask

  task automatic test_repeated_overlap();
    pix_t q[$];
    for (int i = 0; i < 40; i++) q.push_back(mk_pix(300 + i, 20, 1'b1, 8'h20));
    q.push_back(mk_pix(H_LAST, V_LAST, 1'b1, 8'h20));
    play_frame(q, "repeat_slot5");
  endtask

  task automatic test_frame_end_overlap();
    pix_t q[$];
    q.push_back(rand_pix(1'b0));
    q.push_back(mk_pix(H_LAST, V_LAST, 1'b1, 8'h48));
    play_frame(q, "frame_end_px");
  endtask

  task automatic test_drain_ignored();
    pix_t q[$];
    q.push_back(rand_pix(1'b0));
    q.push_back(mk_pix(H_LAST, V_LAST, 1'b0, 8'hFF));
    play_frame(q, "drain_ignored");
    q.delete();
    q.push_back(rand_pix(1'b0));
    q.push_back(mk_pix(H_LAST, V_LAST, 1'b0, 8'h00));
    play_frame(q, "after_drain");
  endtask

  task automatic test_scoreboard();
    pix_t q[$];
    int   start;
    start = score;
    for (int f = 0; f < 3; f++) begin
      q.delete();
      q.push_back(rand_pix(1'b0));
      q.push_back(mk_pix(10 + f, 10, 1'b1, 8'h01 << $urandom_range(0, N - 1)));
      q.push_back(mk_pix(H_LAST, V_LAST, 1'b0, 8'h00));
      play_frame(q, "score_frame");
    end
    checks++;
    if (score - start !== 3) begin
      errors++;
      $display("FAIL scoreboard: got %0d kills expected 3", score - start);
    end
  endtask

  task automatic test_reset_mid_drain();
    pix_t q[$];
    q.push_back(mk_pix(5, 5, 1'b1, 8'b0100_0010));
    q.push_back(mk_pix(H_LAST, V_LAST, 1'b0, 8'h00));
    foreach (q[i]) apply(q[i]);
    apply(rand_pix(1'b0));   // visits slot 0
    apply(rand_pix(1'b0));   // slot 1 reported now
    checks++;
    if (killed !== 1'b1 || kill_slot !== 8'h02) begin
      errors++;
      $display("FAIL mid_drain slot1: killed=%b kill_slot=%h expected 1 02", killed, kill_slot);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (killed !== 1'b0 || kill_slot !== 8'h00 || bullet_hit !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_drain async_clear: killed=%b kill_slot=%h bullet_hit=%b busy=%b expected all 0",
               killed, kill_slot, bullet_hit, busy);
    end
    @(negedge clk);
    apply(rand_pix(1'b1));
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply(rand_pix(1'b0));
      checks++;
      if (killed !== 1'b0 || bullet_hit !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset cyc%0d: killed=%b bullet_hit=%b busy=%b expected 0 0 0",
                 i, killed, bullet_hit, busy);
      end
    end
    q.delete();
    q.push_back(mk_pix(H_LAST, V_LAST, 1'b0, 8'h00));
    play_frame(q, "post_reset_empty");
    // First edge after a reset release must already accumulate.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    q.push_back(mk_pix(7, 7, 1'b1, 8'h08));
    q.push_back(mk_pix(H_LAST, V_LAST, 1'b0, 8'h00));
    play_frame(q, "first_edge");
  endtask

  task automatic test_random();
    pix_t q[$];
    for (int f = 0; f < 12; f++) begin
      q.delete();
      for (int i = 0; i < $urandom_range(1, 20); i++) begin
        pix_t p;
        p = rand_pix(1'b1);
        if ($urandom_range(0, 3) != 0) p.b = 1'b0;
        q.push_back(p);
      end
      q.push_back(mk_pix(H_LAST, V_LAST, 1'($urandom), 8'($urandom)));
      play_frame(q, "random_frame");
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_slot();
    test_multi_overlap();
    test_repeated_overlap();
    test_frame_end_overlap();
    test_drain_ignored();
    test_scoreboard();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
